// File: rtl/prach_hb1_sched_if.sv
// Sample and status bundle between the PRACH hb1 input scheduler and its
// neighbours. master drives samples and control, slave is the scheduler.
interface prach_hb1_sched_if #(
  parameter int CHN_WIDTH = 8
);
  // sample input side
  logic signed [15:0]    din_dq;
  logic                  din_dv;
  logic [CHN_WIDTH-1:0]  din_chn;
  logic                  sync_in;
  logic                  clr_sticky;

  // TDM output side toward hb1
  logic signed [15:0]    dout_dp1;
  logic signed [15:0]    dout_dp2;
  logic                  dout_dv;
  logic [CHN_WIDTH-1:0]  dout_chn;
  logic                  sync_out;

  // status
  logic                  underrun;
  logic                  overrun;
  logic [15:0]           underrun_cnt;
  logic [15:0]           overrun_cnt;

  modport master (
    output din_dq, din_dv, din_chn, sync_in, clr_sticky,
    input  dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out,
    input  underrun, overrun, underrun_cnt, overrun_cnt
  );

  modport slave (
    input  din_dq, din_dv, din_chn, sync_in, clr_sticky,
    output dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out,
    output underrun, overrun, underrun_cnt, overrun_cnt
  );
endinterface

// File: rtl/prach_hb1_sched.sv
// PRACH hb1 input scheduler.
// Pairs consecutive samples of each channel (arriving in any channel order)
// into polyphase pairs and presents them to hb1 in a fixed TDM frame, one
// channel slot per clock, channels 0..NUM_CHANNEL-1 repeating. The frame is
// never stretched: a slot without a pending pair is marked invalid and
// flagged as underrun; a pair that overwrites an unissued one flags overrun.
// Optional build macro PRACH_HB1_SCHED_STATUS_EN adds 16-bit saturating
// underrun/overrun event counters; without it the counter ports read 0.
module prach_hb1_sched #(
  parameter int NUM_CHANNEL = 16,
  parameter int CHN_WIDTH   = 8
) (
  input  logic              clk,
  input  logic              rst,
  prach_hb1_sched_if.slave  bus
);

  localparam int                   IDX_W     = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1;
  localparam logic [IDX_W-1:0]     LAST_SLOT = IDX_W'(NUM_CHANNEL - 1);
  localparam logic [CHN_WIDTH-1:0] NUM_CHN_C = CHN_WIDTH'(NUM_CHANNEL);

  // ---------------------------------------------------------------------
  // Per-channel pairing state
  // ---------------------------------------------------------------------
  logic [NUM_CHANNEL-1:0] phase_r;     // 1: an even sample is staged
  logic [NUM_CHANNEL-1:0] pending_r;   // 1: a full pair waits for its slot
  logic signed [15:0]     stage_r  [NUM_CHANNEL];
  logic signed [15:0]     buf_p1_r [NUM_CHANNEL];
  logic signed [15:0]     buf_p2_r [NUM_CHANNEL];

  // ---------------------------------------------------------------------
  // Slot sequencing state
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0]       slot_r;
  logic [IDX_W-1:0]       slot_nxt_s;
  logic                   first_frame_r;   // underrun masked while set
  logic                   first_frame_nxt_s;

  // ---------------------------------------------------------------------
  // Decisions for the current clock
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0]       din_idx_s;
  logic                   din_ok_s;
  logic                   complete_s;
  logic                   issue_s;
  logic                   underrun_ev_s;
  logic                   overrun_ev_s;

  // ---------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------
  logic signed [15:0]     dout_dp1_r;
  logic signed [15:0]     dout_dp2_r;
  logic                   dout_dv_r;
  logic [CHN_WIDTH-1:0]   dout_chn_r;
  logic                   sync_out_r;
  logic                   underrun_r;
  logic                   overrun_r;

  assign din_idx_s = bus.din_chn[IDX_W-1:0];

  // Slot register and first-frame marker; sync_in restarts the frame at slot 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_r        <= '0;
      first_frame_r <= 1'b1;
    end else begin
      slot_r        <= slot_nxt_s;
      first_frame_r <= first_frame_nxt_s;
    end
  end

  // Next slot, and whether the current slot issues a pair or underruns
  always_comb begin
    slot_nxt_s        = slot_r;
    first_frame_nxt_s = first_frame_r;
    issue_s           = 1'b0;
    underrun_ev_s     = 1'b0;
    if (bus.sync_in) begin
      // Restart: pending pairs are being discarded, so nothing is issued
      // and a missing pair is not an underrun.
      slot_nxt_s        = '0;
      first_frame_nxt_s = 1'b1;
    end else begin
      issue_s       = pending_r[slot_r];
      underrun_ev_s = !pending_r[slot_r] && !first_frame_r;
      if (slot_r == LAST_SLOT) begin
        slot_nxt_s        = '0;
        first_frame_nxt_s = 1'b0;
      end else begin
        slot_nxt_s        = slot_r + IDX_W'(1);
        first_frame_nxt_s = first_frame_r;
      end
    end
  end

  // Input qualification: pair completion and overwrite of an unissued pair
  always_comb begin
    din_ok_s     = 1'b0;
    complete_s   = 1'b0;
    overrun_ev_s = 1'b0;
    if (bus.din_dv && (bus.din_chn < NUM_CHN_C)) begin
      din_ok_s = 1'b1;
      if (!bus.sync_in && phase_r[din_idx_s]) begin
        complete_s = 1'b1;
        // A pair leaving through its slot this same clock is not lost.
        overrun_ev_s = pending_r[din_idx_s] &&
                       !(issue_s && (din_idx_s == slot_r));
      end else begin
        complete_s   = 1'b0;
        overrun_ev_s = 1'b0;
      end
    end else begin
      din_ok_s = 1'b0;
    end
  end

  // Per-channel staging, pair buffers, phase and pending bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_r   <= '0;
      pending_r <= '0;
      for (int k = 0; k < NUM_CHANNEL; k++) begin
        stage_r[k]  <= 16'sd0;
        buf_p1_r[k] <= 16'sd0;
        buf_p2_r[k] <= 16'sd0;
      end
    end else if (bus.sync_in) begin
      // Drop partial and pending pairs; a sample arriving now starts fresh.
      phase_r   <= '0;
      pending_r <= '0;
      if (din_ok_s) begin
        stage_r[din_idx_s] <= bus.din_dq;
        phase_r[din_idx_s] <= 1'b1;
      end
    end else begin
      if (issue_s) begin
        pending_r[slot_r] <= 1'b0;
      end
      // Placed after the issue clear so a same-clock completion keeps
      // the channel pending with the new pair.
      if (din_ok_s) begin
        if (complete_s) begin
          buf_p2_r[din_idx_s]  <= stage_r[din_idx_s];
          buf_p1_r[din_idx_s]  <= bus.din_dq;
          phase_r[din_idx_s]   <= 1'b0;
          pending_r[din_idx_s] <= 1'b1;
        end else begin
          stage_r[din_idx_s]   <= bus.din_dq;
          phase_r[din_idx_s]   <= 1'b1;
        end
      end
    end
  end

  // TDM output stage, one clock behind the slot decision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_dp1_r <= 16'sd0;
      dout_dp2_r <= 16'sd0;
      dout_dv_r  <= 1'b0;
      dout_chn_r <= '0;
      sync_out_r <= 1'b0;
    end else begin
      dout_chn_r <= CHN_WIDTH'(slot_r);
      sync_out_r <= (slot_r == IDX_W'(0));
      if (issue_s) begin
        dout_dp1_r <= buf_p1_r[slot_r];
        dout_dp2_r <= buf_p2_r[slot_r];
        dout_dv_r  <= 1'b1;
      end else begin
        dout_dp1_r <= 16'sd0;
        dout_dp2_r <= 16'sd0;
        dout_dv_r  <= 1'b0;
      end
    end
  end

  // Sticky status flags; a new event in the clearing clock keeps the flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      underrun_r <= underrun_ev_s | (underrun_r & ~bus.clr_sticky);
      overrun_r  <= overrun_ev_s  | (overrun_r  & ~bus.clr_sticky);
    end
  end

  assign bus.dout_dp1 = dout_dp1_r;
  assign bus.dout_dp2 = dout_dp2_r;
  assign bus.dout_dv  = dout_dv_r;
  assign bus.dout_chn = dout_chn_r;
  assign bus.sync_out = sync_out_r;
  assign bus.underrun = underrun_r;
  assign bus.overrun  = overrun_r;

`ifdef PRACH_HB1_SCHED_STATUS_EN
  logic [15:0] underrun_cnt_r;
  logic [15:0] overrun_cnt_r;

  // Saturating increment: counters hold at all-ones
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  // Event counters; clearing clock still records its own event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_cnt_r <= 16'd0;
      overrun_cnt_r  <= 16'd0;
    end else if (bus.clr_sticky) begin
      underrun_cnt_r <= {15'd0, underrun_ev_s};
      overrun_cnt_r  <= {15'd0, overrun_ev_s};
    end else begin
      if (underrun_ev_s) begin
        underrun_cnt_r <= sat_inc(underrun_cnt_r);
      end
      if (overrun_ev_s) begin
        overrun_cnt_r <= sat_inc(overrun_cnt_r);
      end
    end
  end

  assign bus.underrun_cnt = underrun_cnt_r;
  assign bus.overrun_cnt  = overrun_cnt_r;
`else
  assign bus.underrun_cnt = 16'd0;
  assign bus.overrun_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_prach_hb1_sched.sv
// Directed self-checking bench for prach_hb1_sched.
// Inputs change 1 ns after the rising edge; outputs are read at the same
// point, so each read shows the result of the edge just taken.
`timescale 1ns/1ps
module tb_prach_hb1_sched;
  localparam int NUM_CHANNEL = 16;
  localparam int CHN_WIDTH   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   nslot = 0;   // slot the next edge will present

  prach_hb1_sched_if #(.CHN_WIDTH(CHN_WIDTH)) bus ();

  prach_hb1_sched #(
    .NUM_CHANNEL(NUM_CHANNEL),
    .CHN_WIDTH  (CHN_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    nslot = (nslot + 1) % NUM_CHANNEL;
  endtask

  task automatic tick_until(input int k);
    while (nslot != k) tick();
  endtask

  task automatic idle_inputs();
    bus.din_dv     = 1'b0;
    bus.din_chn    = '0;
    bus.din_dq     = 16'sd0;
    bus.sync_in    = 1'b0;
    bus.clr_sticky = 1'b0;
  endtask

  task automatic put(input int chn, input logic [15:0] dq);
    bus.din_dv  = 1'b1;
    bus.din_chn = CHN_WIDTH'(chn);
    bus.din_dq  = dq;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    nslot = 0;
  endtask

  task automatic test_reset();
    logic [CHN_WIDTH+3:0] got;
    logic [CHN_WIDTH+3:0] exp;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({bus.dout_dp1, bus.dout_dp2, bus.dout_dv, bus.dout_chn, bus.sync_out,
         bus.underrun, bus.overrun} !== '0) begin
      n_err++;
      $display("FAIL reset_values: got dp1=%h dp2=%h dv=%b chn=%0d sync=%b un=%b ov=%b want all 0",
               bus.dout_dp1, bus.dout_dp2, bus.dout_dv, bus.dout_chn, bus.sync_out,
               bus.underrun, bus.overrun);
    end
    rst = 1'b0;
    nslot = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      got = {bus.sync_out, bus.dout_chn, bus.dout_dv, bus.underrun, bus.overrun};
      exp = {((i % 16) == 0), CHN_WIDTH'(i % 16), 1'b0, (i >= 16), 1'b0};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL idle_frame cycle %0d: got {sync,chn,dv,un,ov}=%h want %h", i + 1, got, exp);
      end
    end
  endtask

  task automatic test_pair();
    logic [CHN_WIDTH+32:0] got;
    do_reset();
    put(3, 16'h0100); tick();
    put(3, 16'h0200); tick();
    idle_inputs();
    tick_until(3); tick();
    got = {bus.dout_chn, bus.dout_dv, bus.dout_dp2, bus.dout_dp1};
    n_cmp++;
    if (got !== {8'd3, 1'b1, 16'h0100, 16'h0200}) begin
      n_err++;
      $display("FAIL pair_ch3: got {chn,dv,dp2,dp1}=%h want %h", got, {8'd3, 1'b1, 16'h0100, 16'h0200});
    end
    tick_until(3); tick();
    got = {bus.dout_chn, bus.dout_dv, bus.dout_dp2, bus.dout_dp1};
    n_cmp++;
    if (got !== {8'd3, 1'b0, 16'h0000, 16'h0000}) begin
      n_err++;
      $display("FAIL pair_ch3_cleared: got {chn,dv,dp2,dp1}=%h want %h", got, {8'd3, 1'b0, 32'h0});
    end
    n_cmp++;
    if (bus.underrun !== 1'b1) begin
      n_err++;
      $display("FAIL pair_underrun_frame1: got %b want 1", bus.underrun);
    end
  endtask

  task automatic test_invalid_chn();
    logic [CHN_WIDTH+32:0] got;
    do_reset();
    put(0, 16'h1111);   tick();
    put(16, 16'h2222);  tick();
    put(200, 16'h3333); tick();
    put(0, 16'h4444);   tick();
    idle_inputs();
    tick_until(0); tick();
    got = {bus.dout_chn, bus.dout_dv, bus.dout_dp2, bus.dout_dp1};
    n_cmp++;
    if (got !== {8'd0, 1'b1, 16'h1111, 16'h4444}) begin
      n_err++;
      $display("FAIL invalid_chn_ignored: got {chn,dv,dp2,dp1}=%h want %h", got, {8'd0, 1'b1, 16'h1111, 16'h4444});
    end
    put(16, 16'h5555); tick();
    put(16, 16'h6666); tick();
    idle_inputs();
    tick_until(0); tick();
    n_cmp++;
    if (bus.dout_dv !== 1'b0) begin
      n_err++;
      $display("FAIL invalid_chn_no_pair: got dv=%b want 0", bus.dout_dv);
    end
  endtask

  task automatic test_overrun();
    logic [CHN_WIDTH+32:0] got;
    do_reset();
    put(5, 16'h0A0A); tick();
    put(5, 16'h0B0B); tick();
    put(5, 16'h0C0C); tick();
    n_cmp++;
    if (bus.overrun !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_early: got %b want 0", bus.overrun);
    end
    put(5, 16'h0D0D); tick();
    n_cmp++;
    if (bus.overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_set: got %b want 1", bus.overrun);
    end
    idle_inputs();
    tick_until(5); tick();
    got = {bus.dout_chn, bus.dout_dv, bus.dout_dp2, bus.dout_dp1};
    n_cmp++;
    if (got !== {8'd5, 1'b1, 16'h0C0C, 16'h0D0D}) begin
      n_err++;
      $display("FAIL overrun_newest_pair: got {chn,dv,dp2,dp1}=%h want %h", got, {8'd5, 1'b1, 16'h0C0C, 16'h0D0D});
    end
    bus.clr_sticky = 1'b1; tick();
    bus.clr_sticky = 1'b0;
    n_cmp++;
    if (bus.overrun !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_clear: got %b want 0", bus.overrun);
    end
    put(12, 16'h00A1); tick();
    put(12, 16'h00B2); tick();
    put(12, 16'h00C3); tick();
    put(12, 16'h00D4); bus.clr_sticky = 1'b1; tick();
    idle_inputs();
    n_cmp++;
    if (bus.overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_event_beats_clear: got %b want 1", bus.overrun);
    end
    bus.clr_sticky = 1'b1; tick();
    bus.clr_sticky = 1'b0;
    n_cmp++;
    if (bus.overrun !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_clear2: got %b want 0", bus.overrun);
    end
    tick_until(12); tick();
    got = {bus.dout_chn, bus.dout_dv, bus.dout_dp2, bus.dout_dp1};
    n_cmp++;
    if (got !== {8'd12, 1'b1, 16'h00C3, 16'h00D4}) begin
      n_err++;
      $display("FAIL overrun_ch12_pair: got {chn,dv,dp2,dp1}=%h want %h", got, {8'd12, 1'b1, 16'h00C3, 16'h00D4});
    end
  endtask

  task automatic test_same_cycle();
    logic [CHN_WIDTH+32:0] got;
    do_reset();
    put(7, 16'h7001); tick();
    put(7, 16'h7002); tick();
    put(7, 16'h7003); tick();
    idle_inputs();
    tick_until(7);
    put(7, 16'h7004); tick();
    idle_inputs();
    got = {bus.dout_chn, bus.dout_dv, bus.dout_dp2, bus.dout_dp1};
    n_cmp++;
    if (got !== {8'd7, 1'b1, 16'h7001, 16'h7002}) begin
      n_err++;
      $display("FAIL same_cycle_old_pair: got {chn,dv,dp2,dp1}=%h want %h", got, {8'd7, 1'b1, 16'h7001, 16'h7002});
    end
    n_cmp++;
    if (bus.overrun !== 1'b0) begin
      n_err++;
      $display("FAIL same_cycle_no_overrun: got %b want 0", bus.overrun);
    end
    tick_until(7); tick();
    got = {bus.dout_chn, bus.dout_dv, bus.dout_dp2, bus.dout_dp1};
    n_cmp++;
    if (got !== {8'd7, 1'b1, 16'h7003, 16'h7004}) begin
      n_err++;
      $display("FAIL same_cycle_new_pair: got {chn,dv,dp2,dp1}=%h want %h", got, {8'd7, 1'b1, 16'h7003, 16'h7004});
    end
  endtask

  task automatic test_sync();
    logic [CHN_WIDTH+32:0] got;
    logic [CHN_WIDTH+2:0]  st;
    do_reset();
    repeat (20) tick();
    put(2, 16'h0E01); tick();
    idle_inputs();
    tick_until(9);
    bus.sync_in = 1'b1; bus.clr_sticky = 1'b1; put(2, 16'h0E02); tick();
    nslot = 0;
    bus.sync_in = 1'b0; bus.clr_sticky = 1'b0; put(2, 16'h0E03); tick();
    idle_inputs();
    st = {bus.sync_out, bus.dout_chn, bus.dout_dv, bus.underrun};
    n_cmp++;
    if (st !== {1'b1, 8'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL sync_restart: got {sync,chn,dv,un}=%h want %h", st, {1'b1, 8'd0, 1'b0, 1'b0});
    end
    tick_until(2); tick();
    got = {bus.dout_chn, bus.dout_dv, bus.dout_dp2, bus.dout_dp1};
    n_cmp++;
    if (got !== {8'd2, 1'b1, 16'h0E02, 16'h0E03}) begin
      n_err++;
      $display("FAIL sync_phase_cleared: got {chn,dv,dp2,dp1}=%h want %h", got, {8'd2, 1'b1, 16'h0E02, 16'h0E03});
    end
    tick_until(0);
    n_cmp++;
    if (bus.underrun !== 1'b0) begin
      n_err++;
      $display("FAIL sync_underrun_masked: got %b want 0", bus.underrun);
    end
    tick();
    n_cmp++;
    if (bus.underrun !== 1'b1) begin
      n_err++;
      $display("FAIL sync_underrun_after_frame: got %b want 1", bus.underrun);
    end
    bus.sync_in = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      tick();
      st = {bus.sync_out, bus.dout_chn, bus.dout_dv, 1'b0};
      n_cmp++;
      if (st !== {1'b1, 8'd0, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL sync_held %0d: got {sync,chn,dv,0}=%h want %h", i, st, {1'b1, 8'd0, 2'b00});
      end
    end
    bus.sync_in = 1'b0;
    nslot = 0;
    tick();
    tick();
    n_cmp++;
    if ({bus.sync_out, bus.dout_chn} !== {1'b0, 8'd1}) begin
      n_err++;
      $display("FAIL sync_release: got {sync,chn}=%h want %h", {bus.sync_out, bus.dout_chn}, {1'b0, 8'd1});
    end
  endtask

  task automatic test_midframe_reset();
    logic [CHN_WIDTH+32:0] got;
    do_reset();
    repeat (3) tick();
    put(4, 16'h4AAA); tick();
    idle_inputs();
    tick();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.dout_chn, bus.sync_out, bus.dout_dv} !== '0) begin
      n_err++;
      $display("FAIL midframe_reset_async: got {chn,sync,dv}=%h want 0", {bus.dout_chn, bus.sync_out, bus.dout_dv});
    end
    tick();
    rst = 1'b0;
    nslot = 0;
    put(4, 16'h4BBB); tick();
    put(4, 16'h4CCC); tick();
    idle_inputs();
    tick_until(4); tick();
    got = {bus.dout_chn, bus.dout_dv, bus.dout_dp2, bus.dout_dp1};
    n_cmp++;
    if (got !== {8'd4, 1'b1, 16'h4BBB, 16'h4CCC}) begin
      n_err++;
      $display("FAIL midframe_reset_partial_dropped: got {chn,dv,dp2,dp1}=%h want %h", got, {8'd4, 1'b1, 16'h4BBB, 16'h4CCC});
    end
  endtask

  task automatic test_status_cnt();
    logic [15:0] exp_cnt;
`ifdef PRACH_HB1_SCHED_STATUS_EN
    exp_cnt = 16'hFFFF;
`else
    exp_cnt = 16'h0000;
`endif
    do_reset();
    repeat (70000) tick();
    n_cmp++;
    if (bus.underrun_cnt !== exp_cnt) begin
      n_err++;
      $display("FAIL underrun_cnt_sat: got %0d want %0d", bus.underrun_cnt, exp_cnt);
    end
    n_cmp++;
    if (bus.overrun_cnt !== 16'h0000) begin
      n_err++;
      $display("FAIL overrun_cnt_idle: got %0d want 0", bus.overrun_cnt);
    end
    bus.sync_in = 1'b1; bus.clr_sticky = 1'b1; tick();
    idle_inputs();
    nslot = 0;
    n_cmp++;
    if ({bus.underrun_cnt, bus.underrun} !== {16'h0000, 1'b0}) begin
      n_err++;
      $display("FAIL status_clear: got cnt=%0d un=%b want cnt=0 un=0", bus.underrun_cnt, bus.underrun);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_pair();
    test_invalid_chn();
    test_overrun();
    test_same_cycle();
    test_sync();
    test_midframe_reset();
    test_status_cnt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
